time_keeper: RTL
================

# time_keeper

Free-running mm:ss timekeeping core for the digital clock. Divides the system clock into a 1 s tick and advances four BCD digits from 00:00 to 59:59 with wrap. Freezes while the time-set block is in set mode and loads the set block's edited digits when set mode is exited. Its cur_* outputs are the current-time source the set block captures on entry to set mode.

## Interface
- TICK_DIV, 100_000_000, system clock cycles per second; legal range ≥ 2; prescaler width $clog2(TICK_DIV)
- CLK  input  1  system clock; all logic on posedge
- RESET  input  1  synchronous, active-high reset
- enable  input  1  set-mode flag from the time-set block; high = editing
- update_min10  input  4  edited tens-of-minutes digit, BCD 0–5
- update_min01  input  4  edited minutes digit, BCD 0–9
- update_sec10  input  4  edited tens-of-seconds digit, BCD 0–5
- update_sec01  input  4  edited seconds digit, BCD 0–9
- cur_min10  output  4  current tens-of-minutes, registered
- cur_min01  output  4  current minutes, registered
- cur_sec10  output  4  current tens-of-seconds, registered
- cur_sec01  output  4  current seconds, registered
- sec_tick  output  1  one-cycle pulse on every cycle the time advances
- wrap  output  1  one-cycle pulse on the cycle 59:59 advances to 00:00

## Operation
- State machine with three states:
  - RUN: counting.
  - SET: frozen.
  - LOAD: one-cycle capture.
- Transitions, evaluated at each posedge:
  - RUN → SET when enable = 1.
  - SET stays in SET while enable = 1.
  - SET → LOAD when enable = 0.
  - LOAD → SET if enable = 1, else LOAD → RUN.
- RUN:
  - Prescaler counts 0 … TICK_DIV−1.
  - At TICK_DIV−1 the prescaler returns to 0 and the time advances by one second.
  - A RUN cycle that also sees enable = 1 does not advance and does not count; it moves to SET.
- Advance cascade:
  - sec01 9→0 carries into sec10; otherwise sec01+1.
  - sec10 5→0 carries into min01.
  - min01 9→0 carries into min10.
  - min10 5→0.
  - All four digits update in the same cycle.
- SET: cur_* hold, prescaler held at 0, sec_tick and wrap held at 0.
- LOAD:
  - cur_* ← update_*, with per-digit validation: a digit above its limit (min10/sec10 > 5, min01/sec01 > 9) loads as 0.
  - Prescaler ← 0.
  - LOAD exists because update_* from the set block are registered one cycle behind its button handling; sampling one cycle after enable falls captures the final edit.
- sec_tick and wrap are registered outputs. They are high exactly in the cycle cur_* show the new value.
- RESET has priority over everything:
  - cur_* = 0, prescaler = 0, state = RUN, sec_tick = 0, wrap = 0.
  - An edit in progress is discarded.

## Timing
- Reset values: all cur_* 0, sec_tick 0, wrap 0; state RUN.
- First tick after reset or LOAD: cur_* advance at the TICK_DIV-th posedge after the posedge that left RESET/LOAD.
- Thereafter one advance every TICK_DIV cycles exactly; no drift.
- Freeze latency: enable sampled high at edge k → state SET after edge k; no advance occurs at edge k even if the prescaler was at TICK_DIV−1.
- Load latency: enable sampled low at edge k (state SET) → LOAD after k → cur_* = update_* after edge k+1 → counting resumes with prescaler 0.
- enable pulsing 1 for a single cycle still passes through SET then LOAD; cur_* are replaced by update_*.
- wrap is coincident with sec_tick, never alone.

## Test plan
- Reset/count, TICK_DIV=4: RESET 1 cycle, run 12 cycles → cur = 00:03, sec_tick high on cycles 4, 8, 12 after reset release only.
- Rollover, TICK_DIV=4: load 59:58 via enable 1→0 with update = 5,9,5,8; wait 8 cycles → 59:59 then 00:00; wrap high exactly once, on the 00:00 cycle, together with sec_tick.
- Freeze: counting at 00:07 with prescaler at 3, raise enable → no advance, cur stays 00:07 for 20 cycles, sec_tick stays 0.
- Load timing: update = 3,4,2,1, drop enable at edge k → cur = 34:21 after edge k+1, next advance to 34:22 at edge k+1+TICK_DIV.
- Validation: load update = 7,9,6,12 → cur = 09:00.
- Reset mid-operation: assert RESET while in SET and while in LOAD → cur = 00:00, state RUN, next cycle counts from prescaler 0.

Source files
------------

// File: rtl/time_keeper.sv
// Free-running mm:ss timekeeping core: divides CLK into a 1 s tick and advances
// four BCD digits 00:00..59:59, freezing during set mode and loading edited digits on exit.
module time_keeper #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       enable,
    input  logic [3:0] update_min10,
    input  logic [3:0] update_min01,
    input  logic [3:0] update_sec10,
    input  logic [3:0] update_sec01,
    output logic [3:0] cur_min10,
    output logic [3:0] cur_min01,
    output logic [3:0] cur_sec10,
    output logic [3:0] cur_sec01,
    output logic       sec_tick,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SET  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t        state_r;
    logic [PW-1:0] presc_r;
    logic [3:0]    min10_r;
    logic [3:0]    min01_r;
    logic [3:0]    sec10_r;
    logic [3:0]    sec01_r;
    logic          sec_tick_r;
    logic          wrap_r;

    logic [3:0]    min10_nxt_s;
    logic [3:0]    min01_nxt_s;
    logic [3:0]    sec10_nxt_s;
    logic [3:0]    sec01_nxt_s;
    logic          c_s01_s;
    logic          c_s10_s;
    logic          c_m01_s;
    logic          c_m10_s;

    // Out-of-range edited digits are forced to 0 rather than loaded.
    function automatic logic [3:0] valid_digit(input logic [3:0] d, input logic [3:0] lim);
        valid_digit = (d > lim) ? 4'd0 : d;
    endfunction

    // Carry chain of the one-second advance; >= keeps a corrupted digit from escaping its range.
    always_comb begin
        c_s01_s = (sec01_r >= 4'd9);
        c_s10_s = c_s01_s && (sec10_r >= 4'd5);
        c_m01_s = c_s10_s && (min01_r >= 4'd9);
        c_m10_s = c_m01_s && (min10_r >= 4'd5);
    end

    // Next value of each digit after one advance.
    always_comb begin
        sec01_nxt_s = sec01_r;
        sec10_nxt_s = sec10_r;
        min01_nxt_s = min01_r;
        min10_nxt_s = min10_r;
        if (c_s01_s) begin
            sec01_nxt_s = 4'd0;
        end else begin
            sec01_nxt_s = sec01_r + 4'd1;
        end
        if (c_s10_s) begin
            sec10_nxt_s = 4'd0;
        end else if (c_s01_s) begin
            sec10_nxt_s = sec10_r + 4'd1;
        end else begin
            sec10_nxt_s = sec10_r;
        end
        if (c_m01_s) begin
            min01_nxt_s = 4'd0;
        end else if (c_s10_s) begin
            min01_nxt_s = min01_r + 4'd1;
        end else begin
            min01_nxt_s = min01_r;
        end
        if (c_m10_s) begin
            min10_nxt_s = 4'd0;
        end else if (c_m01_s) begin
            min10_nxt_s = min10_r + 4'd1;
        end else begin
            min10_nxt_s = min10_r;
        end
    end

    // Mode FSM with prescaler, time digits and the registered tick/wrap pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_RUN;
            presc_r    <= PRESC_ZERO;
            min10_r    <= 4'd0;
            min01_r    <= 4'd0;
            sec10_r    <= 4'd0;
            sec01_r    <= 4'd0;
            sec_tick_r <= 1'b0;
            wrap_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (enable) begin
                        // Entering set mode wins over a due tick.
                        state_r    <= ST_SET;
                        presc_r    <= PRESC_ZERO;
                        sec_tick_r <= 1'b0;
                        wrap_r     <= 1'b0;
                    end else if (presc_r == PRESC_LAST) begin
                        presc_r    <= PRESC_ZERO;
                        min10_r    <= min10_nxt_s;
                        min01_r    <= min01_nxt_s;
                        sec10_r    <= sec10_nxt_s;
                        sec01_r    <= sec01_nxt_s;
                        sec_tick_r <= 1'b1;
                        wrap_r     <= c_m10_s;
                    end else begin
                        presc_r    <= presc_r + PRESC_ONE;
                        sec_tick_r <= 1'b0;
                        wrap_r     <= 1'b0;
                    end
                end
                ST_SET: begin
                    presc_r    <= PRESC_ZERO;
                    sec_tick_r <= 1'b0;
                    wrap_r     <= 1'b0;
                    if (!enable) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_SET;
                    end
                end
                ST_LOAD: begin
                    // Sampled one cycle after enable falls so the set block's final edit is visible.
                    min10_r    <= valid_digit(update_min10, 4'd5);
                    min01_r    <= valid_digit(update_min01, 4'd9);
                    sec10_r    <= valid_digit(update_sec10, 4'd5);
                    sec01_r    <= valid_digit(update_sec01, 4'd9);
                    presc_r    <= PRESC_ZERO;
                    sec_tick_r <= 1'b0;
                    wrap_r     <= 1'b0;
                    if (enable) begin
                        state_r <= ST_SET;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    presc_r    <= PRESC_ZERO;
                    sec_tick_r <= 1'b0;
                    wrap_r     <= 1'b0;
                end
            endcase
        end
    end

    assign cur_min10 = min10_r;
    assign cur_min01 = min01_r;
    assign cur_sec10 = sec10_r;
    assign cur_sec01 = sec01_r;
    assign sec_tick  = sec_tick_r;
    assign wrap      = wrap_r;

endmodule
